coef_rej_sampler: RTL
=====================

Name: coef_rej_sampler

Overview:
- Upstream feeder for the 24x4096 coefficient RAM (port A).
- Consumes an XOF byte stream and forms 23-bit candidates from 3 bytes each.
- Rejection-samples the candidates against modulus Q. Writes accepted coefficients to consecutive RAM addresses starting at a base address, until N_COEF coefficients are stored.
- Sits between the SHAKE squeeze interface and the polynomial RAM that feeds the NTT.

Parameters:
- Q, 8380417, modulus; a candidate is accepted iff it is < Q.
- N_COEF, 256, number of accepted coefficients per run.
- ADDR_W, 12, RAM address width.
- DATA_W, 24, RAM data width; the accepted value is zero-extended to this width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- base_addr  in  ADDR_W  first write address, sampled on start.
- s_data  in  8  stream byte.
- s_valid  in  1  byte valid.
- s_ready  out  1  byte ready.
- ram_we  out  1  write enable to RAM port A.
- ram_addr  out  ADDR_W  RAM write address.
- ram_din  out  DATA_W  RAM write data.
- busy  out  1  high from the cycle after accepted start until the cycle done pulses.
- done  out  1  one-cycle completion pulse.
- rej_cnt  out  16  rejected-candidate count; present only with REJ_STATS_EN.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; s_ready, ram_we, busy, done = 0; ram_addr, ram_din = 0; byte index = 0; accepted count = 0; rej_cnt = 0.
- States: IDLE -> COLLECT on start. COLLECT -> FINISH when the N_COEF-th acceptance is decided. FINISH -> IDLE after one cycle.
- IDLE:
  - s_ready = 0.
  - On start: latch base_addr, clear byte index and count, enter COLLECT.
- COLLECT:
  - s_ready = 1; a byte transfers when s_valid & s_ready.
  - Bytes arrive little-endian as b0, b1, b2.
  - Candidate = {b2[6:0], b1, b0} (23 bits); b2[7] is discarded.
- Decision: combinational, on the cycle b2 transfers.
  - Accept (candidate < Q): next edge sets ram_we=1, ram_addr = base + count (mod 2^ADDR_W, wraps), ram_din = zero-extended candidate, and count increments.
  - Reject: ram_we stays 0; rej_cnt increments (saturating at 0xFFFF).
- Latency: ram_we is high exactly on the cycle after b2 transfers; ram_we is a one-cycle pulse per accepted candidate.
- Throughput: at most one write per 3 transferred bytes; gaps in s_valid only stall the build-up of the current candidate.
- Completion: the acceptance that makes count == N_COEF moves the state to FINISH on the same edge. s_ready is 0 from that edge, so no further byte is consumed.
- FINISH: done=1 for one cycle, asserted together with the final ram_we pulse. busy falls on the same edge done rises.
- start while busy: ignored.
- Reset mid-run: the partial candidate is discarded and no write is issued.
- The address wraps modulo 4096 with no error.
- The same byte stream and base address always produce the same writes and the same rej_cnt.

Optional Feature:
- Macro: COEF_REJ_STATS_EN.
- Defined: port rej_cnt exists. It counts rejected candidates, saturates at 0xFFFF, clears on an accepted start and on reset, and holds its value after done until the next start.
- Undefined: port rej_cnt and its counter are absent. All other behaviour is identical.

Test Plan:
- Accept path: base=0x000, N_COEF=1, bytes 0x01,0x00,0x00 -> one cycle after b2, ram_we=1, ram_addr=0x000, ram_din=0x000001. done=1 on that same cycle, then s_ready=0.
- Rejection boundary: bytes 0x00,0xE0,0x7F then 0x01,0xE0,0x7F -> first accepted (8380416 = Q-1); second rejected (= Q), no ram_we, rej_cnt=1.
- Mask bit: bytes 0xFF,0xFF,0xFF -> candidate 0x7FFFFF rejected. Bytes 0x05,0x00,0x80 -> accepted, ram_din=0x000005.
- Wrap: base=0xFF0, N_COEF=256, stream of all-accepted bytes -> 256 writes, addresses 0xFF0..0xFFF then 0x000..0x0EF, and done after the 256th write.
- Stall/ignore: s_valid toggled randomly during a run -> identical write sequence; a start pulse mid-run has no effect. rst_n=0 after byte b1 -> no write, all outputs 0, then a new start succeeds normally.

Source files
------------

// File: rtl/coef_rej_sampler_if.sv
// rtl/coef_rej_sampler_if.sv - byte stream in / RAM port A out bundle for coef_rej_sampler
interface coef_rej_sampler_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
);
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;

  modport master (
    output s_data, s_valid,
    input  s_ready, ram_we, ram_addr, ram_din
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/coef_rej_sampler.sv
// rtl/coef_rej_sampler.sv - XOF bytes to rejection-sampled coefficients; COEF_REJ_STATS_EN adds rej_cnt
module coef_rej_sampler #(
  parameter int Q      = 8380417,
  parameter int N_COEF = 256,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  coef_rej_sampler_if.slave bus,
  output logic              busy,
  output logic              done
`ifdef COEF_REJ_STATS_EN
  ,
  output logic [15:0]       rej_cnt
`endif
);

  localparam int CNT_W = $clog2(N_COEF + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, FINISH} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        byte_idx;
  logic [7:0]        b0;
  logic [7:0]        b1;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] base;
  logic [23:0]       cand;
  logic              xfer;
  logic              last_byte;
  logic              accept;
  logic              final_accept;
  logic              run_start;

  // b2[7] is masked off so the candidate is 23 bits wide
  assign cand         = {bus.s_data & 8'h7f, b1, b0};
  assign xfer         = bus.s_valid && (state == COLLECT);
  assign last_byte    = xfer && (byte_idx == 2'd2);
  assign accept       = last_byte && (cand < 24'(Q));
  assign final_accept = accept && (count == CNT_W'(N_COEF - 1));
  assign run_start    = (state == IDLE) && start;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: if (final_accept) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      COLLECT: begin
        bus.s_ready = 1'b1;
        busy        = 1'b1;
      end
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_idx     <= 2'd0;
      b0           <= 8'h00;
      b1           <= 8'h00;
      count        <= '0;
      base         <= '0;
      bus.ram_we   <= 1'b0;
      bus.ram_addr <= '0;
      bus.ram_din  <= '0;
    end else begin
      bus.ram_we <= accept;
      if (accept) begin
        // address wraps naturally in ADDR_W bits
        bus.ram_addr <= base + ADDR_W'(count);
        bus.ram_din  <= DATA_W'(cand);
        count        <= count + 1'b1;
      end
      if (run_start) begin
        base     <= base_addr;
        byte_idx <= 2'd0;
        count    <= '0;
      end else if (xfer) begin
        case (byte_idx)
          2'd0:    begin b0 <= bus.s_data; byte_idx <= 2'd1; end
          2'd1:    begin b1 <= bus.s_data; byte_idx <= 2'd2; end
          default: byte_idx <= 2'd0;
        endcase
      end
    end
  end

`ifdef COEF_REJ_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rej_cnt <= 16'h0000;
    end else if (run_start) begin
      rej_cnt <= 16'h0000;
    end else if (last_byte && !accept && (rej_cnt != 16'hffff)) begin
      rej_cnt <= rej_cnt + 16'h0001;
    end
  end
`endif

endmodule
